// File: rtl/gcd_sched.sv
// Round-robin scheduler sharing one GCD engine between two requesters.
// Define GCD_SCHED_TIMEOUT_EN to add a WAIT-state watchdog (limit TMO).
module gcd_sched #(
    parameter int WIDTH = 4,
    parameter int TMO   = 63
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             rq0,
    input  logic             rq1,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] y0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] g0,
    output logic [WIDTH-1:0] g1,
    output logic             err0,
    output logic             err1,
    output logic [WIDTH-1:0] eng_x,
    output logic [WIDTH-1:0] eng_y,
    output logic             eng_go,
    input  logic             eng_done,
    input  logic [WIDTH-1:0] eng_result,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

    state_t           state;
    state_t           state_n;
    logic             gnt;
    logic             last;
    logic             gnt_n;
    logic             zero;
    logic             tmo_hit;
    logic             res_we;
    logic [WIDTH-1:0] byp;
    logic [WIDTH-1:0] res_val;

    // On a tie the requester not served last wins; a lone request always wins.
    assign gnt_n = (rq0 & rq1) ? ~last : rq1;
    assign zero  = (eng_x == '0) || (eng_y == '0);
    assign byp   = (eng_x == '0) ? eng_y : eng_x;

`ifdef GCD_SCHED_TIMEOUT_EN
    localparam int WW = $clog2(TMO + 1);

    logic [WW-1:0] wdog;
    logic          e0;
    logic          e1;

    assign tmo_hit = (state == WAIT) && !eng_done
                     && (wdog == WW'(TMO - 1));

    always_ff @(posedge clk) begin
        if (!clr) begin
            wdog <= '0;
            e0   <= 1'b0;
            e1   <= 1'b0;
        end else begin
            if (state == WAIT) wdog <= wdog + 1'b1;
            else               wdog <= '0;
            if (res_we && !gnt) e0 <= tmo_hit;
            if (res_we && gnt)  e1 <= tmo_hit;
        end
    end

    assign err0 = e0;
    assign err1 = e1;
`else
    logic unused_tmo;

    assign unused_tmo = (TMO > 0);
    assign tmo_hit    = 1'b0;
    assign err0       = 1'b0;
    assign err1       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!clr) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (rq0 | rq1) state_n = LOAD;
            LOAD: state_n = zero ? RESP : WAIT;
            WAIT: if (eng_done || tmo_hit) state_n = RESP;
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        eng_go = (state == LOAD) && !zero;
        ack0   = (state == RESP) && !gnt;
        ack1   = (state == RESP) && gnt;
        busy   = (state != IDLE);
    end

    // Result source: bypass value, engine output, or zero on timeout.
    always_comb begin
        res_we  = 1'b0;
        res_val = byp;
        if (state == LOAD && zero) begin
            res_we = 1'b1;
        end else if (state == WAIT && eng_done) begin
            res_we  = 1'b1;
            res_val = eng_result;
        end else if (tmo_hit) begin
            res_we  = 1'b1;
            res_val = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            gnt   <= 1'b0;
            last  <= 1'b1;
            eng_x <= '0;
            eng_y <= '0;
            g0    <= '0;
            g1    <= '0;
        end else begin
            if (state == IDLE && (rq0 | rq1)) begin
                gnt   <= gnt_n;
                eng_x <= gnt_n ? x1 : x0;
                eng_y <= gnt_n ? y1 : y0;
            end
            if (res_we && !gnt) g0 <= res_val;
            if (res_we && gnt)  g1 <= res_val;
            if (state == RESP)  last <= gnt;
        end
    end

endmodule

// File: tb/tb_gcd_sched.sv
// Randomized bench for gcd_sched with a behavioural engine and reference model.
// Build with GCD_SCHED_TIMEOUT_EN to exercise the watchdog path.
module tb_gcd_sched;

    logic       clk;
    logic       clr;
    logic       rq0, rq1;
    logic [3:0] x0, y0, x1, y1;
    logic       ack0, ack1;
    logic [3:0] g0, g1;
    logic       err0, err1;
    logic [3:0] eng_x, eng_y;
    logic       eng_go;
    logic       eng_done;
    logic [3:0] eng_result;
    logic       busy;

    int tests = 0;
    int fails = 0;

    int         elat;
    bit         pend;
    int         cnt;
    logic [3:0] eres;
    int         gocnt = 0;

    bit         mlast;
    logic [3:0] mg0, mg1;

    gcd_sched #(.WIDTH(4), .TMO(63)) dut (
        .clk(clk), .clr(clr),
        .rq0(rq0), .rq1(rq1),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .ack0(ack0), .ack1(ack1),
        .g0(g0), .g1(g1),
        .err0(err0), .err1(err1),
        .eng_x(eng_x), .eng_y(eng_y),
        .eng_go(eng_go), .eng_done(eng_done),
        .eng_result(eng_result), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Behavioural engine: done arrives elat cycles after go (never if elat==0).
    always @(posedge clk) begin
        if (eng_go === 1'b1 && elat > 0) begin
            pend = 1;
            cnt  = elat;
            eres = 4'(gcd(int'(eng_x), int'(eng_y)));
        end
        #1;
        eng_done = 1'b0;
        if (pend) begin
            if (cnt <= 1) begin
                eng_done   = 1'b1;
                eng_result = eres;
                pend       = 0;
            end else begin
                cnt--;
            end
        end
    end

    always @(negedge clk) if (eng_go === 1'b1) gocnt++;

    // Cycle index (1 = cycle the request appears) of the ack, 0 if none.
    task automatic wait_ack(input int bound, output int n);
        n = 0;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                n = i;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        @(posedge clk);
        #1;
        clr = 0; rq0 = 0; rq1 = 0;
        @(posedge clk);
        #1;
        clr = 1;
        mlast = 1; mg0 = 0; mg1 = 0;
    endtask

    task automatic test_reset;
        rq0 = 1; x0 = 4'd5; y0 = 4'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({busy, ack0, ack1, eng_go} !== 4'b0) begin
            fails++;
            $display("FAIL reset_ctl got %b want 0000", {busy, ack0, ack1, eng_go});
        end
        tests++;
        if ({g0, g1, eng_x, eng_y} !== 16'h0) begin
            fails++;
            $display("FAIL reset_data got %h want 0000", {g0, g1, eng_x, eng_y});
        end
        tests++;
        if ({err0, err1} !== 2'b00) begin
            fails++;
            $display("FAIL reset_err got %b want 00", {err0, err1});
        end
        @(posedge clk);
        #1;
        rq0 = 0; clr = 1;
        mlast = 1; mg0 = 0; mg1 = 0;
    endtask

    task automatic test_basic;
        int n, go0;
        elat = 5;
        go0 = gocnt;
        x0 = 4'd12; y0 = 4'd8; rq0 = 1;
        wait_ack(40, n);
        tests++;
        if (n != 8) begin
            fails++;
            $display("FAIL basic_latency got %0d want 8", n);
        end
        tests++;
        if ({ack0, ack1, g0, err0} !== {2'b10, 4'd4, 1'b0}) begin
            fails++;
            $display("FAIL basic_result got ack=%b%b g0=%0d err0=%b want 10/4/0",
                     ack0, ack1, g0, err0);
        end
        @(posedge clk);
        #1;
        rq0 = 0;
        mlast = 0; mg0 = 4'd4;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || ack0 !== 1'b0) begin
            fails++;
            $display("FAIL basic_after got busy=%b ack0=%b want 0 0", busy, ack0);
        end
        tests++;
        if (gocnt - go0 != 1) begin
            fails++;
            $display("FAIL basic_go_count got %0d want 1", gocnt - go0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_tie;
        int n;
        bit p0, p1, w;
        logic [3:0] e;
        do_reset();
        elat = 2;
        for (int r = 0; r < 2; r++) begin
            x0 = 4'd9; y0 = 4'd6; x1 = 4'd10; y1 = 4'd15;
            rq0 = 1; rq1 = 1; p0 = 1; p1 = 1;
            for (int k = 0; k < 2; k++) begin
                w = (p0 & p1) ? ~mlast : p1;
                e = w ? 4'd5 : 4'd3;
                wait_ack(40, n);
                tests++;
                if (n != 3 + elat) begin
                    fails++;
                    $display("FAIL tie_latency r%0d k%0d got %0d want %0d", r, k, n, 3 + elat);
                end
                tests++;
                if ({ack1, ack0} !== (w ? 2'b10 : 2'b01)) begin
                    fails++;
                    $display("FAIL tie_order r%0d k%0d got %b%b want winner %0d",
                             r, k, ack1, ack0, w);
                end
                if (w) mg1 = e;
                else   mg0 = e;
                tests++;
                if (g0 !== mg0 || g1 !== mg1) begin
                    fails++;
                    $display("FAIL tie_result r%0d k%0d got %0d,%0d want %0d,%0d",
                             r, k, g0, g1, mg0, mg1);
                end
                @(posedge clk);
                #1;
                if (w) begin rq1 = 0; p1 = 0; end
                else   begin rq0 = 0; p0 = 0; end
                mlast = w;
            end
        end
    endtask

    task automatic test_bypass;
        int n, go0;
        logic [3:0] bx[3] = '{4'd0, 4'd0, 4'd5};
        logic [3:0] by[3] = '{4'd7, 4'd0, 4'd0};
        logic [3:0] be[3] = '{4'd7, 4'd0, 4'd5};
        for (int i = 0; i < 3; i++) begin
            go0 = gocnt;
            x1 = bx[i]; y1 = by[i]; rq1 = 1;
            wait_ack(20, n);
            tests++;
            if (n != 3 || ack1 !== 1'b1 || g1 !== be[i]) begin
                fails++;
                $display("FAIL bypass_%0d got n=%0d ack1=%b g1=%0d want 3/1/%0d",
                         i, n, ack1, g1, be[i]);
            end
            @(posedge clk);
            #1;
            rq1 = 0;
            mg1 = be[i]; mlast = 1;
            tests++;
            if (gocnt != go0) begin
                fails++;
                $display("FAIL bypass_go_%0d got %0d pulses want 0", i, gocnt - go0);
            end
        end
    endtask

    task automatic test_reset_mid;
        int n, acks, bz;
        elat = 10;
        x0 = 4'd6; y0 = 4'd4; rq0 = 1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        clr = 0; rq0 = 0;
        @(posedge clk);
        #1;
        clr = 1;
        mlast = 1; mg0 = 0; mg1 = 0;
        acks = 0; bz = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (ack0 || ack1) acks++;
            if (busy) bz++;
        end
        tests++;
        if (acks != 0 || bz != 0) begin
            fails++;
            $display("FAIL reset_mid got acks=%0d busy_cycles=%0d want 0 0", acks, bz);
        end
        @(posedge clk);
        #1;
        elat = 3;
        x1 = 4'd8; y1 = 4'd12; rq1 = 1;
        wait_ack(40, n);
        tests++;
        if (n != 6 || ack1 !== 1'b1 || g1 !== 4'd4 || g0 !== 4'd0) begin
            fails++;
            $display("FAIL reset_mid_new got n=%0d ack1=%b g1=%0d g0=%0d want 6/1/4/0",
                     n, ack1, g1, g0);
        end
        @(posedge clk);
        #1;
        rq1 = 0;
        mg1 = 4'd4; mlast = 1;
    endtask

    task automatic test_random;
        int n;
        bit p0, p1, w, bp;
        logic [3:0] e;
        for (int it = 0; it < 40; it++) begin
            elat = $urandom_range(1, 6);
            x0 = 4'($urandom); y0 = 4'($urandom);
            x1 = 4'($urandom); y1 = 4'($urandom);
            if ($urandom_range(0, 4) == 0) x0 = 0;
            if ($urandom_range(0, 4) == 0) y1 = 0;
            {p1, p0} = 2'($urandom_range(1, 3));
            rq0 = p0; rq1 = p1;
            while (p0 | p1) begin
                w  = (p0 & p1) ? ~mlast : p1;
                e  = w ? 4'(gcd(int'(x1), int'(y1))) : 4'(gcd(int'(x0), int'(y0)));
                bp = w ? (x1 == 0 || y1 == 0) : (x0 == 0 || y0 == 0);
                wait_ack(40, n);
                tests++;
                if (n != (bp ? 3 : 3 + elat)) begin
                    fails++;
                    $display("FAIL rand_latency it%0d got %0d want %0d",
                             it, n, bp ? 3 : 3 + elat);
                end
                tests++;
                if ({ack1, ack0} !== (w ? 2'b10 : 2'b01)) begin
                    fails++;
                    $display("FAIL rand_grant it%0d got %b%b want winner %0d",
                             it, ack1, ack0, w);
                end
                if (w) mg1 = e;
                else   mg0 = e;
                tests++;
                if (g0 !== mg0 || g1 !== mg1 || {err0, err1} !== 2'b00) begin
                    fails++;
                    $display("FAIL rand_result it%0d got %0d,%0d err=%b%b want %0d,%0d 00",
                             it, g0, g1, err0, err1, mg0, mg1);
                end
                @(posedge clk);
                #1;
                if (w) begin rq1 = 0; p1 = 0; end
                else   begin rq0 = 0; p0 = 0; end
                mlast = w;
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_timeout;
        int n;
        elat = 0;
        x0 = 4'd3; y0 = 4'd5; rq0 = 1;
        wait_ack(100, n);
`ifdef GCD_SCHED_TIMEOUT_EN
        tests++;
        if (n != 66 || ack0 !== 1'b1) begin
            fails++;
            $display("FAIL timeout_latency got n=%0d ack0=%b want 66 1", n, ack0);
        end
        tests++;
        if (err0 !== 1'b1 || g0 !== 4'd0) begin
            fails++;
            $display("FAIL timeout_result got err0=%b g0=%0d want 1 0", err0, g0);
        end
`else
        tests++;
        if (n != 0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL no_timeout got ack_cycle=%0d busy=%b want 0 1", n, busy);
        end
`endif
        do_reset();
    endtask

    initial begin
        clk = 0; clr = 0;
        rq0 = 0; rq1 = 0;
        x0 = 0; y0 = 0; x1 = 0; y1 = 0;
        eng_done = 0; eng_result = 0;
        elat = 5; pend = 0; cnt = 0; eres = 0;
        mlast = 1; mg0 = 0; mg1 = 0;
        test_reset();
        test_basic();
        test_tie();
        test_bypass();
        test_reset_mid();
        test_random();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "bench time limit");
    end

endmodule
